// File: rtl/mips_isa_pkg.sv
// Shared MIPS subset definitions: symbolic ops, primary opcodes, SPECIAL functs
// and field-packing helpers. Also consumed by the control decoder.
package mips_isa_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_ORI = 4'd3,
    OP_LW  = 4'd4,
    OP_SW  = 4'd5,
    OP_BEQ = 4'd6,
    OP_LUI = 4'd7,
    OP_JAL = 4'd8,
    OP_JR  = 4'd9
  } op_e;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_LW      = 6'h23;
  localparam logic [5:0] OPC_SW      = 6'h2B;
  localparam logic [5:0] OPC_BEQ     = 6'h04;
  localparam logic [5:0] OPC_LUI     = 6'h0F;
  localparam logic [5:0] OPC_JAL     = 6'h03;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_JR  = 6'h08;

  // R-type word: SPECIAL opcode, shamt always zero in this subset.
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {OPC_SPECIAL, rs, rt, rd, 5'h00, fn};
  endfunction

  // I-type word with a 16-bit immediate.
  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Instruction word FIFO: DEPTH entries, extra-MSB pointers, registered head.
// Writes are refused when full even if a read happens in the same cycle.
module instr_fifo
  import mips_isa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [W-1:0]  head_r;

  logic          push_s;
  logic          pop_s;
  logic [PW-1:0] rd_next_s;
  logic [AW-1:0] wr_idx_s;
  logic [AW-1:0] rd_next_idx_s;

  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign head  = head_r;

  // Qualified push/pop and the read pointer as it will be after this edge.
  always_comb begin
    push_s        = wr_en && !full;
    pop_s         = rd_en && !empty;
    wr_idx_s      = wr_ptr_r[AW-1:0];
    if (pop_s) begin
      rd_next_s = rd_ptr_r + PW'(1);
    end else begin
      rd_next_s = rd_ptr_r;
    end
    rd_next_idx_s = rd_next_s[AW-1:0];
  end

  // Storage, pointers and head register; the head picks up the incoming word
  // when it lands in the slot that becomes the head (FIFO otherwise empty).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      head_r   <= {W{1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_idx_s] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      rd_ptr_r <= rd_next_s;
      if (push_s && (wr_idx_s == rd_next_idx_s)) begin
        head_r <= wr_data;
      end else begin
        head_r <= mem_r[rd_next_idx_s];
      end
    end
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Packs symbolic MIPS ops into 32-bit words, queues them and streams each word
// with its load address. Illegal ops are consumed, counted and flagged.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] PC_BASE = 32'h0000_3000,
  parameter int          CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [25:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic             err_illegal,
  output logic [CNT_W-1:0] err_count
);

  logic [31:0]      word_s;
  logic             legal_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic [31:0]      addr_r;
  logic             err_r;
  logic [CNT_W-1:0] cnt_r;

  // Encode the requested op; fields an op does not use never reach the word.
  always_comb begin
    word_s  = 32'h0000_0000;
    legal_s = 1'b1;
    case (in_op)
      OP_NOP:  word_s = 32'h0000_0000;
      OP_ADD:  word_s = enc_r(in_rs, in_rt, in_rd, FN_ADD);
      OP_SUB:  word_s = enc_r(in_rs, in_rt, in_rd, FN_SUB);
      OP_ORI:  word_s = enc_i(OPC_ORI, in_rs, in_rt, in_imm[15:0]);
      OP_LW:   word_s = enc_i(OPC_LW,  in_rs, in_rt, in_imm[15:0]);
      OP_SW:   word_s = enc_i(OPC_SW,  in_rs, in_rt, in_imm[15:0]);
      OP_BEQ:  word_s = enc_i(OPC_BEQ, in_rs, in_rt, in_imm[15:0]);
      OP_LUI:  word_s = enc_i(OPC_LUI, 5'h00, in_rt, in_imm[15:0]);
      OP_JAL:  word_s = {OPC_JAL, in_imm};
      OP_JR:   word_s = enc_r(in_rs, 5'h00, 5'h00, FN_JR);
      default: begin
        word_s  = 32'h0000_0000;
        legal_s = 1'b0;
      end
    endcase
  end

  assign in_ready  = !full_s;
  assign out_valid = !empty_s;
  assign accept_s  = in_valid && in_ready;
  assign push_s    = accept_s && legal_s;
  assign pop_s     = out_valid && out_ready;

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_s),
    .wr_data (word_s),
    .rd_en   (pop_s),
    .full    (full_s),
    .empty   (empty_s),
    .head    (out_instr)
  );

  // Load address of the head word plus the illegal-op pulse and saturating count.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r <= PC_BASE;
      err_r  <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (pop_s) begin
        addr_r <= addr_r + 32'd4;
      end
      err_r <= accept_s && !legal_s;
      if (accept_s && !legal_s && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign out_addr    = addr_r;
  assign err_illegal = err_r;
  assign err_count   = cnt_r;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Randomized and directed bench for mips_instr_encoder against a queue model.
module tb_mips_instr_encoder;

  localparam logic [31:0] PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [25:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err_illegal;
  logic [7:0]  err_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mq[$];
  logic [31:0] m_addr;
  logic        m_pulse;
  int          m_cnt;

  always #5 clk = ~clk;

  mips_instr_encoder #(.DEPTH(4), .PC_BASE(PC), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .err_illegal(err_illegal), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference encoding from field positions expressed as powers of two.
  function automatic void ref_word(input logic [3:0] op, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic [4:0] rd,
                                   input logic [25:0] imm,
                                   output logic [31:0] w, output bit legal);
    longint a;
    longint i16;
    longint s;
    longint t;
    longint d;
    i16 = longint'(imm) % 65536;
    s = longint'(rs) * 2097152;
    t = longint'(rt) * 65536;
    d = longint'(rd) * 2048;
    legal = 1'b1;
    case (op)
      4'd0: a = 0;
      4'd1: a = s + t + d + 32;
      4'd2: a = s + t + d + 34;
      4'd3: a = 13 * 67108864 + s + t + i16;
      4'd4: a = 35 * 67108864 + s + t + i16;
      4'd5: a = 43 * 67108864 + s + t + i16;
      4'd6: a = 4 * 67108864 + s + t + i16;
      4'd7: a = 15 * 67108864 + t + i16;
      4'd8: a = 3 * 67108864 + longint'(imm);
      4'd9: a = s + 8;
      default: begin
        a = 0;
        legal = 1'b0;
      end
    endcase
    w = a[31:0];
  endfunction

  task automatic drive(input int op, input int rs, input int rt, input int rd,
                       input int imm, input logic iv, input logic ordy);
    in_op     = 4'(op);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_imm    = 26'(imm);
    in_valid  = iv;
    out_ready = ordy;
  endtask

  // One clock: update the model with the pre-edge state, then check at negedge.
  task automatic cycle();
    logic [31:0] w;
    bit legal;
    bit push;
    bit pop;
    @(posedge clk);
    ref_word(in_op, in_rs, in_rt, in_rd, in_imm, w, legal);
    if (reset) begin
      mq.delete();
      m_addr  = PC;
      m_cnt   = 0;
      m_pulse = 1'b0;
    end else begin
      push = in_valid && (mq.size() < 4);
      pop  = out_ready && (mq.size() > 0);
      m_pulse = push && !legal;
      if (push && !legal && m_cnt < 255) m_cnt++;
      if (pop) begin
        void'(mq.pop_front());
        m_addr = m_addr + 32'd4;
      end
      if (push && legal) mq.push_back(w);
    end
    @(negedge clk);
    chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 4});
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    if (mq.size() > 0) chk("out_instr", out_instr, mq[0]);
    chk("out_addr", out_addr, m_addr);
    chk("err_illegal", {31'd0, err_illegal}, {31'd0, m_pulse});
    chk("err_count", {24'd0, err_count}, 32'(m_cnt));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 1'b0, 1'b1);
    cycle();
    reset = 1'b0;
  endtask

  logic [31:0] seq_w [4];

  initial begin
    m_addr  = PC;
    m_cnt   = 0;
    m_pulse = 1'b0;
    reset   = 1'b1;
    drive(0, 0, 0, 0, 0, 1'b0, 1'b0);
    cycle();
    cycle();
    reset = 1'b0;
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_addr", out_addr, 32'h3000);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);

    // Single ADD
    drive(1, 1, 2, 3, 0, 1'b1, 1'b1);
    cycle();
    drive(0, 0, 0, 0, 0, 1'b0, 1'b1);
    chk("add_word", out_instr, 32'h0022_1820);
    chk("add_addr", out_addr, 32'h0000_3000);
    cycle();

    // ORI / LUI / JAL / JR sequence
    do_reset();
    seq_w = '{32'h3404_FFFF, 32'h3C05_1234, 32'h0C00_0C03, 32'h03E0_0008};
    drive(3, 0, 4, 0, 16'hFFFF, 1'b1, 1'b0); cycle();
    drive(7, 9, 5, 0, 16'h1234, 1'b1, 1'b0); cycle();
    drive(8, 0, 0, 0, 26'h0000C03, 1'b1, 1'b0); cycle();
    drive(9, 31, 0, 0, 0, 1'b1, 1'b0); cycle();
    drive(0, 0, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("seq_word", out_instr, seq_w[i]);
      chk("seq_addr", out_addr, 32'h3000 + 32'(4 * i));
      cycle();
    end

    // Fill to full with consumer stalled, then full+push+pop
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(2, i + 1, i + 2, i + 3, 0, 1'b1, 1'b0);
      cycle();
    end
    chk("full_rdy", {31'd0, in_ready}, 32'd0);
    drive(6, 7, 8, 0, 16'hBEEF, 1'b1, 1'b0);
    cycle();
    cycle();
    chk("stall_rdy", {31'd0, in_ready}, 32'd0);
    drive(6, 7, 8, 0, 16'hBEEF, 1'b1, 1'b1);
    cycle();
    chk("deq_only_rdy", {31'd0, in_ready}, 32'd1);
    cycle();
    drive(0, 0, 0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle();
    chk("drained", {31'd0, out_valid}, 32'd0);

    // Illegal op and saturation
    do_reset();
    drive(12, 1, 2, 3, 4, 1'b1, 1'b1);
    cycle();
    drive(0, 0, 0, 0, 0, 1'b0, 1'b1);
    chk("ill_pulse", {31'd0, err_illegal}, 32'd1);
    chk("ill_count", {24'd0, err_count}, 32'd1);
    chk("ill_novalid", {31'd0, out_valid}, 32'd0);
    cycle();
    for (int i = 0; i < 300; i++) begin
      drive(10 + (i % 6), 0, 0, 0, 0, 1'b1, 1'b1);
      cycle();
    end
    chk("ill_sat", {24'd0, err_count}, 32'h0000_00FF);

    // Reset with 3 words queued
    do_reset();
    drive(13, 0, 0, 0, 0, 1'b1, 1'b0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(4, i, i + 1, 0, 16'h0100 + i, 1'b1, 1'b0);
      cycle();
    end
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 1'b0, 1'b1);
    cycle();
    reset = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_addr", out_addr, 32'h3000);
    chk("mid_rst_cnt", {24'd0, err_count}, 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int op;
      if ($urandom_range(0, 7) == 0) op = $urandom_range(10, 15);
      else op = $urandom_range(0, 9);
      reset = ($urandom_range(0, 299) == 0);
      drive(op, $urandom, $urandom, $urandom, $urandom,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      cycle();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
